// File: rtl/walk_scheduler_if.sv
// Wishbone master/slave bundle between walk_scheduler and the
// LED-walker slave port. Names follow the master's point of view.
interface walk_scheduler_if;
    logic        o_cyc;
    logic        o_stb;
    logic        o_we;
    logic        o_addr;
    logic [31:0] o_data;
    logic        i_stall;
    logic        i_ack;
    logic [31:0] i_data;

    modport master (
        output o_cyc, o_stb, o_we, o_addr, o_data,
        input  i_stall, i_ack, i_data
    );

    modport slave (
        input  o_cyc, o_stb, o_we, o_addr, o_data,
        output i_stall, i_ack, i_data
    );
endinterface

// File: rtl/walk_scheduler.sv
// walk_scheduler: round-robin Wishbone master that starts LED walks
// and polls the walker status register until each walk finishes.
module walk_scheduler #(
    parameter int NREQ     = 4,
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NREQ-1:0] i_req,
    walk_scheduler_if.master bus,
    output logic [NREQ-1:0] o_pending,
    output logic [2:0]      o_active,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WACK, S_GAP, S_RD, S_RACK
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_pending;
    logic [2:0]        r_ptr;
    logic [2:0]        r_active;
    logic [7:0]        r_cnt;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_data;

    logic [2*NREQ-1:0] w_dbl;
    logic              w_found;
    logic [3:0]        w_sum;
    logic [2:0]        w_gnt;
    logic              w_grant;
    logic [NREQ-1:0]   w_clr;
    logic              w_done;
    logic              w_err;
    logic              w_tmo;
    logic              w_cnt_clr;
    logic              w_unused;

    assign w_grant   = (r_state == S_IDLE) && w_found;
    assign w_tmo     = (r_cnt == 8'(TIMEOUT - 1));
    assign w_cnt_clr = (w_state_nxt != r_state)
                    && (w_state_nxt != S_WACK)
                    && (w_state_nxt != S_RACK);
    assign w_unused  = ^bus.i_data[31:4];

    // Rotate pending flags by the pointer and pick the first one set.
    always_comb begin
        w_dbl   = {r_pending, r_pending} >> r_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found = 1'b1;
                w_sum   = 4'(r_ptr) + 4'(i);
            end
        end
        w_gnt = (w_sum >= 4'(NREQ)) ? 3'(w_sum - 4'(NREQ)) : 3'(w_sum);
    end

    // One-hot clear mask for the flag being granted this cycle.
    always_comb begin
        w_clr = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_clr[k] = w_grant && (w_gnt == 3'(k));
        end
    end

    // Next-state logic: write, wait ack, gap, poll, repeat until idle.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_WR;
            end
            S_WR: begin
                if (!bus.i_stall) begin
                    w_state_nxt = S_WACK;
                end else if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end
            end
            S_WACK: begin
                if (bus.i_ack) begin
                    w_state_nxt = S_GAP;
                end else if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == 8'(POLL_GAP - 1)) w_state_nxt = S_RD;
            end
            S_RD: begin
                if (!bus.i_stall) begin
                    w_state_nxt = S_RACK;
                end else if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end
            end
            S_RACK: begin
                if (bus.i_ack) begin
                    if (bus.i_data[3:0] == 4'd0) begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Pending flags, arbitration pointer, counter and registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pending <= '0;
            r_ptr     <= '0;
            r_active  <= '0;
            r_cnt     <= '0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_data    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | i_req;
            if (w_cnt_clr || w_state_nxt == S_IDLE) r_cnt <= '0;
            else                                    r_cnt <= r_cnt + 8'd1;
            if (w_grant) begin
                r_active <= w_gnt;
                r_data   <= {29'd0, w_gnt};
                r_ptr    <= (w_gnt == 3'(NREQ - 1)) ? 3'd0 : w_gnt + 3'd1;
            end
            r_cyc  <= (w_state_nxt == S_WR) || (w_state_nxt == S_WACK)
                   || (w_state_nxt == S_RD) || (w_state_nxt == S_RACK);
            r_stb  <= (w_state_nxt == S_WR) || (w_state_nxt == S_RD);
            r_we   <= (w_state_nxt == S_WR) || (w_state_nxt == S_WACK);
            r_done <= w_done;
            r_err  <= w_err;
        end
    end

    assign bus.o_cyc  = r_cyc;
    assign bus.o_stb  = r_stb;
    assign bus.o_we   = r_we;
    assign bus.o_addr = 1'b0;
    assign bus.o_data = r_data;
    assign o_pending  = r_pending;
    assign o_active   = r_active;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_err      = r_err;
endmodule

// File: doc/walk_scheduler.md
# walk_scheduler

Wishbone bus master that shares one LED-walker peripheral between several independent requesters. Each requester posts a walk request with a single-cycle pulse. The scheduler grants requests round-robin and issues one Wishbone write to start a walk. It then polls the walker's status register until the walk finishes, and only then serves the next requester. It sits between the user-facing request sources (buttons, UART command decoder) and the walker's Wishbone slave port.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- POLL_GAP, 4: idle cycles between status reads (1..255).
- TIMEOUT, 32: maximum cycles from strobe assertion to ack before abort (2..255).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_req  in  NREQ  per-requester walk-request pulse.
- o_cyc  out  1  Wishbone cycle.
- o_stb  out  1  Wishbone strobe.
- o_we  out  1  Wishbone write enable.
- o_addr  out  1  Wishbone address; always 0.
- o_data  out  32  write data: granted requester index, zero-extended.
- i_stall  in  1  slave stall.
- i_ack  in  1  slave ack.
- i_data  in  32  slave read data; bits [3:0] = walker state, 0 = idle.
- o_pending  out  NREQ  sticky pending-request flags.
- o_active  out  3  index of the requester currently being served.
- o_busy  out  1  high whenever the FSM is not IDLE.
- o_done  out  1  one-cycle pulse when a walk completes.
- o_err  out  1  one-cycle pulse on bus timeout.

## Operation
- Reset values: all outputs are 0, including o_pending. The FSM is in IDLE, the round-robin pointer is 0 and all counters are 0.
- Pending flags:
  - i_req[k] sets o_pending[k].
  - The flag clears on the cycle its requester is granted.
  - If a set and a clear of the same bit coincide, the set wins.
  - Repeated pulses while a request is pending coalesce into one request.
- Arbitration:
  - Arbitration happens in IDLE only.
  - The scan starts at the round-robin pointer and picks the first pending index, wrapping from NREQ-1 to 0.
  - On grant, the pointer becomes grant+1 (mod NREQ) and o_active is latched.
- FSM states:
  - IDLE: if any flag is pending, grant it and go to WR.
  - WR: o_cyc=o_stb=o_we=1. Hold all request signals stable while i_stall is high. When i_stall is low, go to WACK.
  - WACK: o_cyc=1, o_stb=0. On i_ack, drop o_cyc and go to GAP.
  - GAP: o_cyc=0. Count POLL_GAP cycles, then go to RD.
  - RD: o_cyc=o_stb=1, o_we=0. Hold while stalled. When accepted, go to RACK.
  - RACK: o_cyc=1. On i_ack, drop o_cyc:
    - if i_data[3:0]==0, pulse o_done and go to IDLE;
    - otherwise go to GAP.
- Timeout:
  - The counter resets on entry to WR or RD and increments every cycle in WR/WACK or RD/RACK.
  - When it reaches TIMEOUT without an ack: drop o_cyc/o_stb, pulse o_err, go to IDLE.
  - The aborted request is consumed, not retried.
- i_ack in GAP or IDLE is ignored.
- o_stb is never high with o_cyc low.
- All bus outputs are registered.

## Timing
- Request-to-strobe latency:
  - i_req[k] at edge t sets o_pending[k] after edge t.
  - If the FSM is IDLE, the grant happens at edge t+1, with o_stb=1 and o_pending[k]=0 after it.
  - Minimum latency is 2 cycles.
- Write accepted at edge a (stb & !stall): o_stb=0 after edge a.
- Ack at edge a+1: o_cyc=0 after it.
- GAP lasts exactly POLL_GAP cycles with o_cyc=0.
- o_done and o_err are asserted for exactly one cycle, on the cycle after the terminating ack or timeout edge.
- o_busy is low on the same cycle o_done is high.
- Reset mid-transaction: o_cyc/o_stb are 0 after the reset edge. Pending flags are lost. An i_req in the reset cycle is dropped.
- Back-to-back service: after o_done, the next pending requester is granted on the following edge, so there is at least one IDLE cycle between walks.

## Test plan
- Single request: pulse i_req=4'b0100 against a walker model (ack 1 cycle after acceptance, state 1..11 then 0).
  -> One write with o_data=2.
  -> Polls spaced by POLL_GAP=4.
  -> o_done once after the read returns 0.
  -> o_pending back to 0.
- Round-robin: pulse i_req=4'b1011 in one cycle.
  -> Grants in order 0, 1, 3.
  -> A new i_req[0] during service of 1 is granted after 3, not before.
- Stall: hold i_stall=1 for 5 cycles during WR.
  -> o_stb/o_we/o_data stable throughout.
  -> Exactly one write accepted.
  -> No timeout while TIMEOUT=32.
- Coalescing: pulse i_req[1] 3 times while it is pending, plus once on its grant cycle.
  -> Exactly 2 walks for requester 1.
- Timeout: slave never acks in RACK.
  -> o_cyc drops 32 cycles after the read strobe.
  -> o_err pulses once.
  -> Next pending requester served.
- Reset: assert i_reset_n=0 during WACK with 2 flags pending.
  -> All outputs 0 after the edge.
  -> No bus activity until a new i_req.
